// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: matrix pins, key event outputs, and the
// FSM state tap for debug.
//
// Handshake: key_valid is a one-cycle strobe that has no ready. key_code,
// digit_new and digit_old change only on the clock edge that raises
// key_valid. They are stable for every cycle between events, so a
// consumer can sample them at any time. key_held is a level, not a strobe.
interface keypad_scanner_if;
    logic [3:0] rows;       // keypad rows, active-low, asynchronous
    logic [3:0] cols;       // column drive, active-low, one-hot-low
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic [1:0] state_dbg;  // 0 SCAN, 1 DEBOUNCE, 2 HELD, 3 RELEASE

    // Keypad/consumer side: drives rows and observes everything else
    modport master (
        output rows,
        input  cols, key_code, key_valid, key_held, digit_new, digit_old,
        input  state_dbg
    );

    // Scanner side
    modport slave (
        input  rows,
        output cols, key_code, key_valid, key_held, digit_new, digit_old,
        output state_dbg
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner.
// It walks the columns, debounces the press and the release of one key,
// and emits one key_valid strobe for each accepted press. It also keeps
// the last two accepted digits for the display mux.
module keypad_scanner #(
    parameter int SCAN_DIV        = 12_000,
    parameter int DEBOUNCE_CYCLES = 240_000
) (
    input logic        clk,
    input logic        reset,
    keypad_scanner_if.slave kp
);

    // One counter serves both as the column dwell timer and as the debounce timer
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [3:0]    rows_m, rows_s;
    logic [CW-1:0] cnt;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [3:0]    key_code_r;
    logic          key_valid_r;
    logic [3:0]    digit_new_r, digit_old_r;

    // Decoded control strobes from the next-state logic
    logic          cnt_clr, cnt_inc, col_adv, capture, accept;

    // Derived row information
    logic          any_low;
    logic [1:0]    low_row;
    logic          row_in;

    // Row map to hex code; rows r0..r3 top to bottom, cols c0..c3 left to right
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines (idle high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_m <= 4'b1111;
            rows_s <= 4'b1111;
        end else begin
            rows_m <= kp.rows;
            rows_s <= rows_m;
        end
    end

    // Pick the lowest-numbered low row; the captured row is watched after that
    always_comb begin
        any_low = ~&rows_s;
        low_row = 2'd3;
        if (!rows_s[0])      low_row = 2'd0;
        else if (!rows_s[1]) low_row = 2'd1;
        else if (!rows_s[2]) low_row = 2'd2;
        row_in  = rows_s[row_idx];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SCAN;
        else       state <= state_next;
    end

    // Next-state logic and datapath control strobes
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        col_adv    = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_clr = 1'b1;
                    if (any_low) begin
                        capture    = 1'b1;
                        state_next = DEBOUNCE;
                    end else begin
                        col_adv = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_in) begin
                    // Press did not survive: abandon it and keep scanning
                    state_next = SCAN;
                    cnt_clr    = 1'b1;
                    col_adv    = 1'b1;
                end else if (cnt == DEB_LAST) begin
                    accept     = 1'b1;
                    state_next = HELD;
                    cnt_clr    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                cnt_clr = 1'b1;
                if (row_in) state_next = RELEASE;
            end
            RELEASE: begin
                if (!row_in) begin
                    // Release bounce: key is still down, no new event
                    state_next = HELD;
                    cnt_clr    = 1'b1;
                end else if (cnt == DEB_LAST) begin
                    state_next = SCAN;
                    cnt_clr    = 1'b1;
                    col_adv    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = SCAN;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    // Output logic: column drive follows the column index, held mirrors the state
    always_comb begin
        kp.cols      = ~(4'b0001 << col_idx);
        kp.key_held  = (state == HELD) || (state == RELEASE);
        kp.state_dbg = state;
    end

    // Counter, column index and captured row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (col_adv)      col_idx <= col_idx + 2'd1;
            if (capture)      row_idx <= low_row;
        end
    end

    // Key event registers: update only on the accepting edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            digit_new_r <= 4'h0;
            digit_old_r <= 4'h0;
        end else begin
            key_valid_r <= accept;
            if (accept) begin
                key_code_r  <= key_lookup(row_idx, col_idx);
                digit_new_r <= key_lookup(row_idx, col_idx);
                digit_old_r <= digit_new_r;
            end
        end
    end

    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.digit_new = digit_new_r;
    assign kp.digit_old = digit_old_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
// A keypad model drives the rows from the pressed-key matrix and the
// column drive. Expected events go into a queue and are checked by a
// separate monitor.
module tb_keypad_scanner;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic        clk;
    logic        reset;
    logic [15:0] pressed;     // bit r*4+c = key at row r, column c is down
    logic [3:0]  rows_model;

    keypad_scanner_if bus ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (bus)
    );

    // Scoreboard state: {key_code, digit_new, digit_old} per expected event
    logic [11:0] exp_q[$];
    logic [3:0]  model_dnew, model_dold;
    logic [3:0]  key_map [16];
    int          n_checks, n_pass, ev_count;
    logic        prev_valid;

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Keypad matrix: a row is pulled low when a pressed key sits on a driven column
    always_comb begin
        for (int r = 0; r < 4; r++)
            rows_model[r] = ~|(pressed[r*4 +: 4] & ~bus.cols);
    end
    assign bus.rows = rows_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_expected(input logic [3:0] code);
        exp_q.push_back({code, code, model_dnew});
        model_dold = model_dnew;
        model_dnew = code;
    endtask

    task automatic wait_event(input int budget, input string name);
        int start;
        logic seen;
        start = ev_count;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #2;
            if (ev_count != start) seen = 1'b1;
        end
        check({name, "_event_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_held_low(input int budget, input string name);
        logic low;
        low = 1'b0;
        for (int i = 0; i < budget && !low; i++) begin
            @(negedge clk);
            if (!bus.key_held) low = 1'b1;
        end
        check({name, "_held_released"}, 32'(low), 32'd1);
    endtask

    // Wait for the first cycle on which the given column becomes driven
    task automatic sync_to_col(input logic [3:0] col_pat, input string name);
        logic [3:0] prev;
        logic hit;
        prev = bus.cols;
        hit  = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.cols == col_pat && prev != col_pat) hit = 1'b1;
            prev = bus.cols;
        end
        check({name, "_col_sync"}, 32'(hit), 32'd1);
    endtask

    // Monitor: every key_valid strobe pops one expected event
    always @(negedge clk) begin
        if (!reset && bus.key_valid) begin
            ev_count++;
            check("valid_one_cycle", 32'(prev_valid), 32'd0);
            check("held_on_event", 32'(bus.key_held), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got code %0h expected no event", bus.key_code);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("ev_key_code", 32'(bus.key_code), 32'(e[11:8]));
                check("ev_digit_new", 32'(bus.digit_new), 32'(e[7:4]));
                check("ev_digit_old", 32'(bus.digit_old), 32'(e[3:0]));
            end
        end
        prev_valid = bus.key_valid;
    end

    initial begin
        int snap;
        key_map = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        n_checks = 0; n_pass = 0; ev_count = 0; prev_valid = 1'b0;
        model_dnew = 4'h0; model_dold = 4'h0;
        pressed = 16'h0;
        reset = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cols", 32'(bus.cols), 32'hE);
        check("rst_key_code", 32'(bus.key_code), 32'h0);
        check("rst_key_valid", 32'(bus.key_valid), 32'h0);
        check("rst_key_held", 32'(bus.key_held), 32'h0);
        check("rst_digits", 32'({bus.digit_new, bus.digit_old}), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'(ST_SCAN));
        reset = 1'b0;

        // Idle scan: each column dwells 4 cycles, no events
        for (int k = 1; k <= 64; k++) begin
            logic [3:0] exp_cols;
            @(negedge clk);
            exp_cols = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("idle_cols_k%0d", k), 32'(bus.cols), 32'(exp_cols));
        end
        check("idle_no_event", 32'(ev_count), 32'd0);
        check("idle_digits", 32'({bus.digit_new, bus.digit_old}), 32'h0);

        // Clean press of "6" (row1, col2)
        push_expected(key_map[6]);
        pressed[6] = 1'b1;
        wait_event(60, "key6");
        snap = ev_count;
        repeat (16) @(negedge clk);
        check("key6_held_high", 32'(bus.key_held), 32'd1);
        check("key6_no_repeat", 32'(ev_count), 32'(snap));
        pressed[6] = 1'b0;
        repeat (10) @(negedge clk);
        check("key6_held_before_debounce", 32'(bus.key_held), 32'd1);
        @(negedge clk);
        check("key6_held_dropped", 32'(bus.key_held), 32'd0);
        check("key6_resume_col3", 32'(bus.cols), 32'h7);
        check("key6_state_scan", 32'(bus.state_dbg), 32'(ST_SCAN));
        check("key6_code_kept", 32'(bus.key_code), 32'h6);

        // "5" then "A", separated by full releases
        push_expected(key_map[5]);
        pressed[5] = 1'b1;
        wait_event(60, "key5");
        repeat (10) @(negedge clk);
        pressed[5] = 1'b0;
        wait_held_low(30, "key5");
        repeat (3) @(negedge clk);
        push_expected(key_map[3]);
        pressed[3] = 1'b1;
        wait_event(60, "keyA");
        repeat (10) @(negedge clk);
        pressed[3] = 1'b0;
        wait_held_low(30, "keyA");
        check("seq_digit_new", 32'(bus.digit_new), 32'hA);
        check("seq_digit_old", 32'(bus.digit_old), 32'h5);
        check("seq_event_count", 32'(ev_count), 32'd3);

        // Bouncing "0" (row3, col1): low 3 cycles, high 1, then low
        sync_to_col(4'b1101, "bounce");
        push_expected(key_map[13]);
        snap = ev_count;
        pressed[13] = 1'b1;
        repeat (3) @(negedge clk);
        pressed[13] = 1'b0;
        @(negedge clk);
        check("bounce_in_debounce", 32'(bus.state_dbg), 32'(ST_DEBOUNCE));
        pressed[13] = 1'b1;
        repeat (2) @(negedge clk);
        check("bounce_abort_scan", 32'(bus.state_dbg), 32'(ST_SCAN));
        check("bounce_abort_col2", 32'(bus.cols), 32'hB);
        check("bounce_no_event", 32'(ev_count), 32'(snap));
        wait_event(60, "key0");
        repeat (5) @(negedge clk);
        pressed[13] = 1'b0;
        wait_held_low(30, "key0");
        check("key0_code", 32'(bus.key_code), 32'h0);

        // "1" and "9" together: "1" wins, "9" follows after "1" is released
        sync_to_col(4'b1110, "dual");
        push_expected(key_map[0]);
        push_expected(key_map[10]);
        pressed[0]  = 1'b1;
        pressed[10] = 1'b1;
        wait_event(40, "key1");
        snap = ev_count;
        repeat (20) @(negedge clk);
        check("dual_no_repeat_1", 32'(ev_count), 32'(snap));
        pressed[0] = 1'b0;
        wait_event(80, "key9");
        snap = ev_count;
        repeat (20) @(negedge clk);
        check("dual_no_repeat_9", 32'(ev_count), 32'(snap));
        pressed[10] = 1'b0;
        wait_held_low(30, "key9");
        check("dual_digits", 32'({bus.digit_new, bus.digit_old}), 32'h91);

        // Reset while "F" is held, then re-detection
        push_expected(key_map[14]);
        pressed[14] = 1'b1;
        wait_event(60, "keyF");
        repeat (3) @(negedge clk);
        check("f_state_held", 32'(bus.state_dbg), 32'(ST_HELD));
        reset = 1'b1;
        #1;
        check("mid_rst_cols", 32'(bus.cols), 32'hE);
        check("mid_rst_key_code", 32'(bus.key_code), 32'h0);
        check("mid_rst_key_held", 32'(bus.key_held), 32'h0);
        check("mid_rst_key_valid", 32'(bus.key_valid), 32'h0);
        check("mid_rst_digits", 32'({bus.digit_new, bus.digit_old}), 32'h0);
        check("mid_rst_state", 32'(bus.state_dbg), 32'(ST_SCAN));
        model_dnew = 4'h0;
        model_dold = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        snap = ev_count;
        repeat (10) @(negedge clk);
        check("post_rst_no_event", 32'(ev_count), 32'(snap));
        check("post_rst_not_held", 32'(bus.key_held), 32'd0);
        push_expected(key_map[14]);
        wait_event(60, "keyF_again");
        repeat (5) @(negedge clk);
        pressed[14] = 1'b0;
        wait_held_low(30, "keyF_again");
        check("f_digits", 32'({bus.digit_new, bus.digit_old}), 32'hF0);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_events", 32'(ev_count), 32'd8);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the dual seven-segment display driver.
- Scans a 4x4 active-low matrix keypad and debounces presses and releases.
- Emits exactly one event per physical keypress.
- Keeps the two most recent hex digits, which feed the display mux directly: digit_new goes to the right display, digit_old to the left.

Parameters:
- SCAN_DIV, 12_000, clk cycles each column is driven before advancing (1 ms at 12 MHz).
- DEBOUNCE_CYCLES, 240_000, consecutive stable cycles required to accept a press or a release (20 ms at 12 MHz).

Ports:
- clk  input  1  system clock (12 MHz)
- reset  input  1  asynchronous, active-high reset
- rows  input  4  keypad row lines; active-low; asynchronous to clk; pulled up off-chip
- cols  output  4  keypad column drive; active-low; one-hot-low while scanning
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_held  output  1  high while an accepted key remains pressed (HELD or RELEASE state)
- digit_new  output  4  most recently accepted digit
- digit_old  output  4  previously accepted digit

Behaviour:
- Reset values (all registers, asynchronous):
  - cols=4'b1110, key_code=0, key_valid=0, key_held=0, digit_new=0, digit_old=0
  - state=SCAN, column index=0, counters=0, synchronizer flops=4'b1111
- Synchronizer:
  - rows passes through a 2-flop synchronizer to give rows_s.
  - All FSM decisions use rows_s only, so there is 2 cycles of input latency.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Counter width is $clog2 of the larger of SCAN_DIV and DEBOUNCE_CYCLES.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - The dwell counter increments every cycle.
  - At dwell==SCAN_DIV-1, sample rows_s.
  - If any bit is low: capture the current column and the lowest-numbered low row. Freeze cols, clear the counter, and go to DEBOUNCE.
  - Otherwise: rotate the column 0→1→2→3→0 (cols 1110→1101→1011→0111→1110) and clear dwell.
- DEBOUNCE:
  - cols stays frozen. The counter increments while the captured row reads low.
  - If the captured row reads high at any cycle: return to SCAN, advance to the next column, clear counters, emit no event.
  - At counter==DEBOUNCE_CYCLES-1 with the row still low, the next edge does the following:
    - key_valid=1 for exactly one cycle
    - key_code=mapped code
    - digit_old<=digit_new, digit_new<=code
    - key_held=1
    - state=HELD
- HELD:
  - cols stays frozen. Other keys pressed meanwhile are ignored.
  - When the captured row reads high, clear the counter and go to RELEASE.
- RELEASE:
  - The counter increments while the captured row reads high.
  - If the row reads low before completion: return to HELD with no new event (bounce on release).
  - At counter==DEBOUNCE_CYCLES-1: key_held=0, go to SCAN, advance to the next column.
- Simultaneous keys:
  - Same column: the lowest row wins.
  - Different columns: the first column scanned wins.
  - A second key still pressed after the first is released is detected on a later scan as a new event.
- Holding a key never repeats key_valid.
- key_code, digit_new and digit_old change only on a key_valid edge.
- Reset asserted mid-operation (any state) immediately forces all reset values. No event is emitted on reset release, even if a key is down; that key is detected afresh via SCAN.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- No key pressed for 64 cycles after reset deasserts → cols cycles 1110,1101,1011,0111, 4 cycles each; key_valid never rises; digits remain 0.
- Clean press of row1/col2 ("6") held 40 cycles, then released → exactly one key_valid pulse; key_code=6, digit_new=6, digit_old=0; key_held high until 8 stable-high cycles after release; scanning then resumes at col3.
- Press "5" then "A", separated by full releases → after the second event digit_new=A, digit_old=5; exactly two key_valid pulses.
- Press of "0" that bounces (row low 3 cycles, high 1, low 20) → the bounce aborts to SCAN with no event; a single event (code 0) follows on a later scan.
- Hold "1" and press "9" at the same time, release "1" while holding "9" → first event 1; second event 9 after the release of "1" is debounced; no repeat events while either key is held.
- Assert reset for 1 cycle while in HELD with key "F" → all outputs return to their reset values immediately, key_held=0, no event on reset release; "F" is re-detected with one key_valid after debounce.
